// File: rtl/mesh_router_param.sv
// Parametrised five-port XY mesh router: per-input FIFOs, per-output round-robin
// arbitration with credit flow control, and a registered crossbar. Ports N=0,S=1,E=2,W=3,L=4.
module mesh_router_param #(
  parameter int         DATA_W  = 16,
  parameter int         COORD_W = 4,
  parameter int         DEPTH   = 4,
  parameter int         XCOORD  = 0,
  parameter int         YCOORD  = 0,
  parameter logic [4:0] PORT_EN = 5'b11111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          in_valid,
  input  logic [5*DATA_W-1:0] in_data,
  output logic [4:0]          credit_out,
  output logic [4:0]          out_valid,
  output logic [5*DATA_W-1:0] out_data,
  input  logic [4:0]          credit_in,
  output logic [4:0]          err_overflow,
  output logic [4:0]          err_noroute
);
  // Handshake: a flit is transferred on every cycle in_valid/out_valid is high; there is
  // no ready. Back-pressure is purely credit-based: one credit pulse per freed FIFO slot.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]      FULL_C = CW'(DEPTH);
  localparam logic [COORD_W-1:0] MY_X   = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] MY_Y   = COORD_W'(YCOORD);

  logic [DATA_W-1:0] mem_q [5][DEPTH];
  logic [PW-1:0]     wr_ptr_q [5];
  logic [PW-1:0]     wr_ptr_d [5];
  logic [PW-1:0]     rd_ptr_q [5];
  logic [PW-1:0]     rd_ptr_d [5];
  logic [CW-1:0]     count_q  [5];
  logic [CW-1:0]     count_d  [5];
  logic [CW-1:0]     credit_q [5];
  logic [CW-1:0]     credit_d [5];
  logic [2:0]        rr_ptr_q [5];
  logic [2:0]        rr_ptr_d [5];
  logic [DATA_W-1:0] out_data_q [5];
  logic [DATA_W-1:0] out_data_d [5];
  logic [4:0]        out_valid_q, out_valid_d;
  logic [4:0]        credit_out_q, credit_out_d;
  logic [4:0]        err_ovf_q, err_ovf_d;
  logic [4:0]        err_nr_q, err_nr_d;

  logic [DATA_W-1:0] head [5];
  logic [2:0]        tgt [5];
  logic [4:0]        req [5];
  logic [3:0]        pick [5];
  logic [2:0]        grant_idx [5];
  logic [4:0]        grant_v;
  logic [4:0]        nonempty, full, noroute, pop, push;

  function automatic logic [2:0] xy_route(input logic [DATA_W-1:0] flit);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2:0]         r;
    dx = flit[2*COORD_W-1:COORD_W];
    dy = flit[COORD_W-1:0];
    if (dx > MY_X)      r = 3'd2;
    else if (dx < MY_X) r = 3'd3;
    else if (dy > MY_Y) r = 3'd0;
    else if (dy < MY_Y) r = 3'd1;
    else                r = 3'd4;
    return r;
  endfunction

  // Returns {found, index}; search starts at ptr and wraps modulo 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] rq, input logic [2:0] ptr);
    logic [3:0] r;
    int         idx;
    r = 4'b0;
    for (int k = 0; k < 5; k++) begin
      idx = (int'(ptr) + k) % 5;
      if (!r[3] && rq[idx]) r = {1'b1, 3'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      head[i]     = mem_q[i][rd_ptr_q[i]];
      tgt[i]      = xy_route(head[i]);
      nonempty[i] = PORT_EN[i] && (count_q[i] != '0);
      full[i]     = (count_q[i] == FULL_C);
      noroute[i]  = nonempty[i] && !PORT_EN[tgt[i]];
    end
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        req[o][i] = nonempty[i] && (tgt[i] == 3'(o)) && PORT_EN[o] && (credit_q[o] != '0);
      end
    end
    // A head with no existing target is discarded so it cannot block its FIFO.
    pop = noroute;
    for (int o = 0; o < 5; o++) begin
      pick[o]      = rr_pick(req[o], rr_ptr_q[o]);
      grant_v[o]   = pick[o][3];
      grant_idx[o] = pick[o][2:0];
      if (grant_v[o]) pop[grant_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      push[i]      = in_valid[i] && PORT_EN[i] && (!full[i] || pop[i]);
      err_ovf_d[i] = err_ovf_q[i] | (in_valid[i] && PORT_EN[i] && full[i] && !pop[i]);
      err_nr_d[i]  = err_nr_q[i] | noroute[i];
      wr_ptr_d[i]  = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i]  = rd_ptr_q[i] + PW'(pop[i]);
      count_d[i]   = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    for (int o = 0; o < 5; o++) begin
      credit_d[o] = credit_q[o];
      if (grant_v[o] && !credit_in[o])
        credit_d[o] = credit_q[o] - CW'(1);
      else if (!grant_v[o] && credit_in[o] && (credit_q[o] != FULL_C))
        credit_d[o] = credit_q[o] + CW'(1);
      rr_ptr_d[o]    = rr_ptr_q[o];
      if (grant_v[o]) rr_ptr_d[o] = (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
      out_valid_d[o] = grant_v[o];
      out_data_d[o]  = grant_v[o] ? head[grant_idx[o]] : '0;
    end
    credit_out_d = pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        count_q[i]    <= '0;
        credit_q[i]   <= FULL_C;
        rr_ptr_q[i]   <= '0;
        out_data_q[i] <= '0;
      end
      out_valid_q  <= '0;
      credit_out_q <= '0;
      err_ovf_q    <= '0;
      err_nr_q     <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        wr_ptr_q[i]   <= wr_ptr_d[i];
        rd_ptr_q[i]   <= rd_ptr_d[i];
        count_q[i]    <= count_d[i];
        credit_q[i]   <= credit_d[i];
        rr_ptr_q[i]   <= rr_ptr_d[i];
        out_data_q[i] <= out_data_d[i];
      end
      out_valid_q  <= out_valid_d;
      credit_out_q <= credit_out_d;
      err_ovf_q    <= err_ovf_d;
      err_nr_q     <= err_nr_d;
    end
  end

  // Storage has no reset; emptiness is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < 5; o++) begin
      if (PORT_EN[o]) out_data[o*DATA_W +: DATA_W] = out_data_q[o];
    end
  end

  assign out_valid    = out_valid_q & PORT_EN;
  assign credit_out   = credit_out_q & PORT_EN;
  assign err_overflow = err_ovf_q & PORT_EN;
  assign err_noroute  = err_nr_q & PORT_EN;

endmodule
